// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register countdown timers for the integer
// and float files, raising stall/bubble while any used source is not yet forwardable.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int ALU_LAT  = 0,
  parameter int FLOAT_EN = 1,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_flush,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_use_rd,
  input  logic                 id_rs_f,
  input  logic                 id_rt_f,
  input  logic                 id_rd_f,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic [REG_AW-1:0]    id_dst,
  input  logic                 id_dst_f,
  output logic                 stall,
  output logic                 bubble,
  output logic [2**REG_AW-1:0] busy_int,
  output logic [2**REG_AW-1:0] busy_flt,
  output logic [CNT_W-1:0]     stall_cycles
);
  localparam int NREG    = 2**REG_AW;
  localparam int MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
  localparam int TW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  logic [TW-1:0] tmr_int [NREG];
  logic [TW-1:0] lat;
  logic          live;
  logic          rs_busy;
  logic          rt_busy;
  logic          rd_busy;
  logic          hazard;
  logic          issue;

  assign live    = id_valid & ~id_flush;
  assign rs_busy = id_use_rs & (id_rs_f ? busy_flt[id_rs] : busy_int[id_rs]);
  assign rt_busy = id_use_rt & (id_rt_f ? busy_flt[id_rt] : busy_int[id_rt]);
  assign rd_busy = id_use_rd & (id_rd_f ? busy_flt[id_rd] : busy_int[id_rd]);
  assign hazard  = live & (rs_busy | rt_busy | rd_busy);
  // integer r0 is hardwired zero, so writes to it never arm a timer
  assign issue   = live & ~hazard & id_reg_write & (id_dst_f | (id_dst != '0));
  assign lat     = id_mem_read ? TW'(LOAD_LAT) : TW'(ALU_LAT);
  assign stall   = hazard;
  assign bubble  = hazard;

  // a fresh issue overrides the decrement so the latest writer defines readiness
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) tmr_int[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (issue && !id_dst_f && (id_dst == REG_AW'(i)))
          tmr_int[i] <= lat;
        else if (tmr_int[i] != '0)
          tmr_int[i] <= tmr_int[i] - TW'(1);
      end
    end
  end

  always_comb begin
    busy_int = '0;
    for (int i = 0; i < NREG; i++) busy_int[i] = (tmr_int[i] != '0);
    busy_int[0] = 1'b0;
  end

  generate
    if (FLOAT_EN != 0) begin : g_flt
      logic [TW-1:0] tmr_flt [NREG];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < NREG; i++) tmr_flt[i] <= '0;
        end else begin
          for (int i = 0; i < NREG; i++) begin
            if (issue && id_dst_f && (id_dst == REG_AW'(i)))
              tmr_flt[i] <= lat;
            else if (tmr_flt[i] != '0)
              tmr_flt[i] <= tmr_flt[i] - TW'(1);
          end
        end
      end

      always_comb begin
        busy_flt = '0;
        for (int i = 0; i < NREG; i++) busy_flt[i] = (tmr_flt[i] != '0);
      end
    end else begin : g_no_flt
      assign busy_flt = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (hazard && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: four parameterisations share one decode stimulus;
// hand-derived expectations are queued per cycle and compared against the selected one.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_flush;
  logic [4:0] id_rs, id_rt, id_rd, id_dst;
  logic       id_use_rs, id_use_rt, id_use_rd;
  logic       id_rs_f, id_rt_f, id_rd_f;
  logic       id_reg_write, id_mem_read, id_dst_f;

  logic        st0, st1, st2, st3, bb0, bb1, bb2, bb3;
  logic [31:0] bi0, bi1, bi2, bi3, bf0, bf1, bf2, bf3;
  logic [31:0] sc0, sc1, sc3;
  logic [3:0]  sc2;

  int          sel;
  logic        o_stall, o_bubble;
  logic [31:0] o_bi, o_bf, o_sc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic stall;
    int   bidx;
    logic bflt;
    logic bexp;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // d0: defaults, d1: LOAD_LAT=2, d2: LOAD_LAT=3 with 4-bit counter, d3: no float file
  hazard_scoreboard u_d0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_rd(id_use_rd),
    .id_rs_f(id_rs_f), .id_rt_f(id_rt_f), .id_rd_f(id_rd_f),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_dst(id_dst), .id_dst_f(id_dst_f),
    .stall(st0), .bubble(bb0), .busy_int(bi0), .busy_flt(bf0), .stall_cycles(sc0));

  hazard_scoreboard #(.LOAD_LAT(2)) u_d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_rd(id_use_rd),
    .id_rs_f(id_rs_f), .id_rt_f(id_rt_f), .id_rd_f(id_rd_f),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_dst(id_dst), .id_dst_f(id_dst_f),
    .stall(st1), .bubble(bb1), .busy_int(bi1), .busy_flt(bf1), .stall_cycles(sc1));

  hazard_scoreboard #(.LOAD_LAT(3), .CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_rd(id_use_rd),
    .id_rs_f(id_rs_f), .id_rt_f(id_rt_f), .id_rd_f(id_rd_f),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_dst(id_dst), .id_dst_f(id_dst_f),
    .stall(st2), .bubble(bb2), .busy_int(bi2), .busy_flt(bf2), .stall_cycles(sc2));

  hazard_scoreboard #(.FLOAT_EN(0)) u_d3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_rd(id_use_rd),
    .id_rs_f(id_rs_f), .id_rt_f(id_rt_f), .id_rd_f(id_rd_f),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_dst(id_dst), .id_dst_f(id_dst_f),
    .stall(st3), .bubble(bb3), .busy_int(bi3), .busy_flt(bf3), .stall_cycles(sc3));

  always_comb begin
    o_stall = st0; o_bubble = bb0; o_bi = bi0; o_bf = bf0; o_sc = sc0;
    case (sel)
      1: begin o_stall = st1; o_bubble = bb1; o_bi = bi1; o_bf = bf1; o_sc = sc1; end
      2: begin o_stall = st2; o_bubble = bb2; o_bi = bi2; o_bf = bf2; o_sc = {28'b0, sc2}; end
      3: begin o_stall = st3; o_bubble = bb3; o_bi = bi3; o_bf = bf3; o_sc = sc3; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (dut %0d) got=%0h exp=%0h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_flush = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_dst = 0;
    id_use_rs = 0; id_use_rt = 0; id_use_rd = 0;
    id_rs_f = 0; id_rt_f = 0; id_rd_f = 0;
    id_reg_write = 0; id_mem_read = 0; id_dst_f = 0;
  endtask

  task automatic load(input logic [4:0] dst, input logic f);
    idle();
    id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_dst = dst; id_dst_f = f;
  endtask

  task automatic alu_wr(input logic [4:0] dst);
    idle();
    id_valid = 1; id_reg_write = 1; id_dst = dst;
  endtask

  // which: 0 = rs, 1 = rt, 2 = rd used as a store source
  task automatic reader(input logic [4:0] src, input logic f, input int which);
    idle();
    id_valid = 1;
    case (which)
      0: begin id_rs = src; id_use_rs = 1; id_rs_f = f; end
      1: begin id_rt = src; id_use_rt = 1; id_rt_f = f; end
      default: begin id_rd = src; id_use_rd = 1; id_rd_f = f; end
    endcase
  endtask

  // called just after a negedge drive; compares before the next posedge
  task automatic step(input logic es, input int bidx = -1, input logic bflt = 0,
                      input logic bexp = 0);
    exp_t e;
    exp_q.push_back('{es, bidx, bflt, bexp});
    #2;
    e = exp_q.pop_front();
    chk("stall", {31'b0, o_stall}, {31'b0, e.stall});
    chk("bubble", {31'b0, o_bubble}, {31'b0, e.stall});
    if (e.bidx >= 0) begin
      if (e.bflt) chk("busy_flt", {31'b0, o_bf[e.bidx]}, {31'b0, e.bexp});
      else        chk("busy_int", {31'b0, o_bi[e.bidx]}, {31'b0, e.bexp});
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int s);
    sel = s;
    @(negedge clk);
    rst = 1; idle();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    sel = 0;
    idle();
    #2;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk("rst_stall", {31'b0, o_stall}, 32'd0);
      chk("rst_busy_int", o_bi, 32'd0);
      chk("rst_busy_flt", o_bf, 32'd0);
      chk("rst_cnt", o_sc, 32'd0);
    end

    // default latencies: load-use on rs gives exactly one bubble
    do_reset(0);
    load(8, 0);    step(0, 8, 0, 0);
    reader(8, 0, 0); step(1, 8, 0, 1); step(0, 8, 0, 0);
    idle();        step(0);
    chk("cnt_one", o_sc, 32'd1);
    load(3, 0);    step(0);
    reader(3, 0, 1); step(1, 3, 0, 1); step(0);
    alu_wr(7);     step(0);
    reader(7, 0, 0); step(0, 7, 0, 0);

    // r0 never busy; f0 is a real register
    load(0, 0);    step(0, 0, 0, 0);
    reader(0, 0, 0); step(0, 0, 0, 0);
    load(0, 1);    step(0, 0, 1, 0);
    reader(0, 1, 0); step(1, 0, 1, 1); step(0, 0, 1, 0);

    // LOAD_LAT=3: store reading rd stalls three cycles
    do_reset(2);
    load(5, 0);    step(0, 5, 0, 0);
    reader(5, 0, 2);
    step(1, 5, 0, 1); step(1, 5, 0, 1); step(1, 5, 0, 1); step(0, 5, 0, 0);
    chk("cnt_three", o_sc, 32'd3);

    // flushed reader never stalls; the next live reader still does; flushed load arms nothing
    do_reset(2);
    load(9, 0);    step(0);
    reader(9, 0, 0); id_flush = 1; step(0, 9, 0, 1);
    reader(9, 0, 0); step(1); step(1); step(0, 9, 0, 0);
    load(10, 0); id_flush = 1; step(0);
    reader(10, 0, 0); step(0, 10, 0, 0);

    // WAW: a later ALU write to r4 cancels the pending load timer
    do_reset(1);
    load(4, 0);    step(0);
    alu_wr(4);     step(0, 4, 0, 1);
    reader(4, 0, 0); step(0, 4, 0, 0);
    load(4, 0);    step(0);
    reader(4, 0, 0); id_reg_write = 1; id_dst = 4;
    step(1); step(1); step(0);
    reader(4, 0, 0); step(0, 4, 0, 0);

    // no float file: float hazards vanish, integer path unaffected
    do_reset(3);
    load(6, 1);    step(0, 6, 1, 0);
    reader(6, 1, 0); step(0, 6, 1, 0);
    load(6, 0);    step(0);
    reader(6, 0, 0); step(1, 6, 0, 1); step(0);

    // reset in the middle of a three-cycle stall
    do_reset(2);
    load(5, 0);    step(0);
    reader(5, 0, 0); step(1);
    rst = 1;
    #1;
    chk("mid_rst_stall", {31'b0, o_stall}, 32'd0);
    chk("mid_rst_busy", o_bi, 32'd0);
    chk("mid_rst_cnt", o_sc, 32'd0);
    @(negedge clk);
    rst = 0;

    // 4-bit stall counter saturates at 15 instead of wrapping
    do_reset(2);
    for (int k = 1; k <= 6; k++) begin
      load(5, 0);      step(0);
      reader(5, 0, 0); step(1); step(1); step(1); step(0);
      if (k == 4) chk("cnt_12", o_sc, 32'd12);
    end
    chk("cnt_sat", o_sc, 32'd15);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
